// File: rtl/conv_layer_scheduler.sv
// ============================================================================
// Module      : conv_layer_scheduler
// Description : Sequences one pass of a convolutional layer over an image held
//               in a synchronous pixel memory. Reads pixels in raster order,
//               clocks them into the layer only while downstream can accept a
//               result, flushes the layer pipeline with zeros once the image is
//               exhausted, and forwards result pixels downstream.
//
// Ports
//   clk               : clock, all logic on rising edge
//   rst_n             : asynchronous active-low reset
//   start             : one-cycle pulse, begins a pass (honoured only when idle)
//   abort             : synchronous cancel of a pass in progress
//   src_addr          : pixel memory read address
//   src_rd_en         : pixel memory read strobe (data valid next cycle)
//   src_data          : pixel memory read data
//   layer_clk_en      : clock enable for the convolutional layer
//   layer_input_data  : pixel fed to the layer (zero outside streaming)
//   layer_valid       : layer result valid
//   layer_output_data : layer result
//   out_data          : result pixel to downstream
//   out_valid         : result pixel present
//   out_ready         : downstream accepts
//   busy              : pass in progress
//   done              : one-cycle pulse, pass complete
//   error             : sticky, flush ran too long; cleared by start
//
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module conv_layer_scheduler #(
    parameter int I_WIDTH      = 8,
    parameter int O_WIDTH      = 16,
    parameter int CHANNELS_IN  = 3,
    parameter int CHANNELS_OUT = 5,
    parameter int IMAGE_WIDTH  = 64,
    parameter int IMAGE_HEIGHT = 32,
    parameter int FILTER_SIZE  = 5,
    parameter int FLUSH_MAX    = 256,
    localparam int N_IN        = IMAGE_WIDTH * IMAGE_HEIGHT,
    localparam int N_OUT       = (IMAGE_WIDTH - FILTER_SIZE + 1) * (IMAGE_HEIGHT - FILTER_SIZE + 1),
    localparam int ADDR_W      = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    output logic [ADDR_W-1:0]                src_addr,
    output logic                             src_rd_en,
    input  logic [CHANNELS_IN*I_WIDTH-1:0]   src_data,
    output logic                             layer_clk_en,
    output logic [CHANNELS_IN*I_WIDTH-1:0]   layer_input_data,
    input  logic                             layer_valid,
    input  logic [CHANNELS_OUT*O_WIDTH-1:0]  layer_output_data,
    output logic [CHANNELS_OUT*O_WIDTH-1:0]  out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             done,
    output logic                             error
);

    localparam int c_OCNT_W = $clog2(N_OUT + 1);
    localparam int c_FCNT_W = $clog2(FLUSH_MAX + 1);

    localparam logic [ADDR_W-1:0]   c_ADDR_LAST  = ADDR_W'(N_IN - 1);
    localparam logic [ADDR_W-1:0]   c_ADDR_ONE   = ADDR_W'(1);
    localparam logic [c_OCNT_W-1:0] c_OCNT_LAST  = c_OCNT_W'(N_OUT - 1);
    localparam logic [c_OCNT_W-1:0] c_OCNT_ONE   = c_OCNT_W'(1);
    localparam logic [c_FCNT_W-1:0] c_FCNT_LAST  = c_FCNT_W'(FLUSH_MAX - 1);
    localparam logic [c_FCNT_W-1:0] c_FCNT_ONE   = c_FCNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRIME  = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    // r_addr is the address of the pixel currently presented on src_data.
    logic [ADDR_W-1:0]     r_addr;
    logic [ADDR_W-1:0]     w_addr_nxt;
    logic [c_OCNT_W-1:0]   r_out_cnt;
    logic [c_OCNT_W-1:0]   w_out_cnt_nxt;
    logic [c_FCNT_W-1:0]   r_flush_cnt;
    logic [c_FCNT_W-1:0]   w_flush_cnt_nxt;
    logic                  r_error;
    logic                  w_error_nxt;

    logic                  w_active;
    logic                  w_xfer;
    logic                  w_last_xfer;

    assign error = r_error;

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_out_cnt   <= '0;
            r_flush_cnt <= '0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_out_cnt   <= w_out_cnt_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_error     <= w_error_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_out_cnt_nxt    = r_out_cnt;
        w_flush_cnt_nxt  = r_flush_cnt;
        w_error_nxt      = r_error;
        src_addr         = r_addr;
        src_rd_en        = 1'b0;
        layer_clk_en     = 1'b0;
        layer_input_data = '0;
        out_data         = '0;
        out_valid        = 1'b0;
        busy             = 1'b1;
        done             = 1'b0;

        w_active    = (r_state == S_STREAM) || (r_state == S_FLUSH);
        w_xfer      = w_active && layer_valid && out_ready;
        w_last_xfer = w_xfer && (r_out_cnt == c_OCNT_LAST);

        // Result forwarding is only meaningful while the layer is running;
        // outside that window the outputs are held at zero.
        if (w_active) begin
            out_valid    = layer_valid;
            out_data     = layer_output_data;
            layer_clk_en = out_ready;
        end

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt     = S_PRIME;
                    w_addr_nxt      = '0;
                    w_out_cnt_nxt   = '0;
                    w_flush_cnt_nxt = '0;
                    w_error_nxt     = 1'b0;
                end
            end

            S_PRIME: begin
                // Fetch pixel 0 so it is on src_data for the first STREAM cycle.
                src_rd_en   = 1'b1;
                src_addr    = '0;
                w_state_nxt = S_STREAM;
            end

            S_STREAM: begin
                layer_input_data = src_data;
                if (out_ready) begin
                    if (r_addr != c_ADDR_LAST) begin
                        // Prefetch the next pixel while the current one is consumed.
                        src_rd_en  = 1'b1;
                        src_addr   = r_addr + c_ADDR_ONE;
                        w_addr_nxt = r_addr + c_ADDR_ONE;
                    end else begin
                        w_state_nxt = S_FLUSH;
                    end
                end
            end

            S_FLUSH: begin
                if (out_ready) begin
                    if (r_flush_cnt == c_FCNT_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_error_nxt = 1'b1;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt + c_FCNT_ONE;
                    end
                end
            end

            S_FINISH: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A completing transfer wins over both a pending FLUSH entry and a
        // flush timeout landing in the same cycle.
        if (w_xfer) begin
            if (w_last_xfer) begin
                w_state_nxt = S_FINISH;
                w_error_nxt = r_error;
            end else begin
                w_out_cnt_nxt = r_out_cnt + c_OCNT_ONE;
            end
        end

        // Abort has the final say, even over a simultaneous transfer.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_error_nxt = r_error;
        end

        // Every return to IDLE leaves the counters cleared.
        if ((w_state_nxt == S_IDLE) && (r_state != S_IDLE)) begin
            w_addr_nxt      = '0;
            w_out_cnt_nxt   = '0;
            w_flush_cnt_nxt = '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_layer_scheduler.sv
// ============================================================================
// Module      : tb_conv_layer_scheduler
// Description : Self-checking bench for conv_layer_scheduler with a pixel
//               memory model and a pipelined convolutional layer stub.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_conv_layer_scheduler;

    localparam int IW    = 8;
    localparam int OW    = 16;
    localparam int CI    = 3;
    localparam int CO    = 5;
    localparam int W     = 64;
    localparam int H     = 32;
    localparam int F     = 5;
    localparam int FM    = 256;
    localparam int N_IN  = W * H;
    localparam int OUT_W = W - F + 1;
    localparam int N_OUT = OUT_W * (H - F + 1);
    localparam int AW    = $clog2(N_IN);
    localparam int LAT   = 3;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [AW-1:0]     src_addr;
    logic              src_rd_en;
    logic [CI*IW-1:0]  src_data;
    logic              layer_clk_en;
    logic [CI*IW-1:0]  layer_input_data;
    logic              layer_valid;
    logic [CO*OW-1:0]  layer_output_data;
    logic [CO*OW-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              error;

    conv_layer_scheduler #(
        .I_WIDTH(IW), .O_WIDTH(OW), .CHANNELS_IN(CI), .CHANNELS_OUT(CO),
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FILTER_SIZE(F), .FLUSH_MAX(FM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .src_addr(src_addr), .src_rd_en(src_rd_en), .src_data(src_data),
        .layer_clk_en(layer_clk_en), .layer_input_data(layer_input_data),
        .layer_valid(layer_valid), .layer_output_data(layer_output_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- pixel memory model ----------------
    logic [CI*IW-1:0] mem [N_IN];
    always @(posedge clk) begin
        if (src_rd_en) src_data <= mem[src_addr];
    end

    // ---------------- convolutional layer stub ----------------
    // Consumes one pixel per enabled clock in raster order; after the pixel
    // that completes an FxF window it emits a tagged result LAT enables later.
    function automatic bit win_end(input int n);
        return (n < N_IN) && ((n / W) >= F - 1) && ((n % W) >= F - 1);
    endfunction

    int               lay_n;
    logic [LAT-1:0]   pv;
    logic [CO*OW-1:0] pd [LAT];
    bit               mute;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lay_n <= 0;
            pv    <= '0;
        end else if (start && !busy) begin
            lay_n <= 0;
            pv    <= '0;
        end else if (layer_clk_en) begin
            lay_n <= lay_n + 1;
            pv    <= {pv[LAT-2:0], win_end(lay_n) && !mute};
            pd[0] <= {32'(lay_n), layer_input_data, 24'(lay_n * 7)};
            for (int s = 1; s < LAT; s++) pd[s] <= pd[s-1];
        end
    end
    assign layer_valid       = pv[LAT-1];
    assign layer_output_data = pd[LAT-1];

    // ---------------- reference: k-th result of a pass ----------------
    function automatic logic [CO*OW-1:0] exp_out(input int k);
        int r, c, idx;
        r   = k / OUT_W;
        c   = k % OUT_W;
        idx = (r + F - 1) * W + (c + F - 1);
        return {32'(idx), mem[idx], 24'(idx * 7)};
    endfunction

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // per-pass observations
    int cyc, exp_addr, addr_err, en_cnt, en_bad, xfer, last_xfer_cyc, done_cnt, done_cyc;
    bit saw_busy, ended;
    int rmode;

    task automatic clear_obs();
        cyc = 0; exp_addr = 0; addr_err = 0; en_cnt = 0; en_bad = 0; xfer = 0;
        last_xfer_cyc = -1; done_cnt = 0; done_cyc = -1; saw_busy = 0; ended = 0;
    endtask

    task automatic sample();
        cyc++;
        if (src_rd_en) begin
            if (src_addr != AW'(exp_addr)) addr_err++;
            exp_addr++;
        end
        if (layer_clk_en) begin
            en_cnt++;
            if (!out_ready) en_bad++;
        end
        if (out_valid && out_ready) begin
            if (xfer < N_OUT) check("out_data", out_data, exp_out(xfer));
            last_xfer_cyc = cyc;
            xfer++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (saw_busy && !busy) ended = 1;
        if (busy) saw_busy = 1;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = !out_ready;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    // kind: 0 normal, 1 flush timeout expected, 2 abort at transfer 500, 3 reset mid-stream
    task automatic run_pass(input int mode, input int kind, input bit noise);
        clear_obs();
        rmode = mode;
        start = 1'b1;
        tick();
        check("error_clr_by_start", error, 1'b0);
        for (int i = 0; i < 30000 && !ended; i++) begin
            if (kind == 2 && xfer >= 500) begin
                abort = 1'b1;
                tick();
                check("abort_busy", busy, 1'b0);
                break;
            end
            if (kind == 3 && cyc == 400) begin
                @(negedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                check("rst_busy", busy, 1'b0);
                check("rst_rd_en", src_rd_en, 1'b0);
                check("rst_addr", src_addr, '0);
                check("rst_clk_en", layer_clk_en, 1'b0);
                check("rst_lin", layer_input_data, '0);
                check("rst_out_valid", out_valid, 1'b0);
                check("rst_out_data", out_data, '0);
                check("rst_done_err", {done, error}, 2'b00);
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
                done_cnt = 0;
                repeat (6) tick();
                check("rst_idle_busy", busy, 1'b0);
                check("rst_idle_rd", src_rd_en, 1'b0);
                check("rst_idle_done", done_cnt, 0);
                break;
            end
            if (noise && (i % 300) == 150 && xfer < N_OUT - 50) start = 1'b1;
            tick();
        end
        case (kind)
            0: begin
                check("pass_end", ended, 1'b1);
                check("rd_count", exp_addr, N_IN);
                check("addr_order_err", addr_err, 0);
                check("xfer_count", xfer, N_OUT);
                check("done_count", done_cnt, 1);
                check("done_timing", done_cyc, last_xfer_cyc + 1);
                check("clk_en_count", en_cnt, N_IN + LAT);
                check("clk_en_stall", en_bad, 0);
                check("error_ok", error, 1'b0);
                check("busy_after", busy, 1'b0);
            end
            1: begin
                check("pass_end_err", ended, 1'b1);
                check("error_set", error, 1'b1);
                check("err_no_done", done_cnt, 0);
                check("err_xfer", xfer, 0);
                check("err_clk_en_count", en_cnt, N_IN + FM);
                check("err_rd_count", exp_addr, N_IN);
            end
            2: begin
                repeat (5) tick();
                check("abort_no_done", done_cnt, 0);
                check("abort_idle_busy", busy, 1'b0);
                check("abort_idle_rd", src_rd_en, 1'b0);
            end
            default: ;
        endcase
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        mute      = 1'b0;
        rmode     = 0;
        for (int a = 0; a < N_IN; a++) mem[a] = (CI*IW)'($urandom);

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_error", error, 1'b0);
        check("reset_rd_en", src_rd_en, 1'b0);
        check("reset_addr", src_addr, '0);
        check("reset_clk_en", layer_clk_en, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();

        run_pass(0, 0, 1'b0);   // free-running downstream
        run_pass(1, 0, 1'b0);   // out_ready toggling every cycle
        run_pass(2, 0, 1'b1);   // random stalls plus start pulses while busy
        mute = 1'b1;
        run_pass(0, 1, 1'b0);   // layer never valid -> flush timeout
        mute = 1'b0;
        run_pass(2, 0, 1'b0);   // start clears error
        run_pass(2, 2, 1'b0);   // abort at transfer 500
        run_pass(0, 0, 1'b0);   // clean restart after abort
        run_pass(2, 3, 1'b0);   // asynchronous reset mid-stream
        run_pass(2, 0, 1'b0);   // clean restart after reset

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv_layer_scheduler.md
CONV_LAYER_SCHEDULER -- requirements
Module: conv_layer_scheduler

Interface
REQ-001 SHALL have parameter I_WIDTH, default 8: bits per input channel sample.
REQ-002 SHALL have parameter O_WIDTH, default 16: bits per output channel sample.
REQ-003 SHALL have parameter CHANNELS_IN, default 3; CHANNELS_OUT, default 5.
REQ-004 SHALL have parameters IMAGE_WIDTH, default 64; IMAGE_HEIGHT, default 32; FILTER_SIZE, default 5.
REQ-005 SHALL have parameter FLUSH_MAX, default 256: maximum flush cycles before error.
REQ-006 SHALL derive N_IN = IMAGE_WIDTH*IMAGE_HEIGHT and N_OUT = (IMAGE_WIDTH-FILTER_SIZE+1)*(IMAGE_HEIGHT-FILTER_SIZE+1).
REQ-007 Ports, one clock; reset is asynchronous and active-low:
  clk  in  1  clock, all logic on rising edge
  rst_n  in  1  asynchronous active-low reset
  start  in  1  one-cycle pulse begins a layer pass
  abort  in  1  synchronous cancel of a pass in progress
  src_addr  out  clog2(N_IN)  input pixel memory read address
  src_rd_en  out  1  memory read strobe; data valid next cycle, held while strobe low
  src_data  in  CHANNELS_IN*I_WIDTH  memory read data
  layer_clk_en  out  1  drives convolutional_layer clk_en
  layer_input_data  out  CHANNELS_IN*I_WIDTH  drives convolutional_layer input_data
  layer_valid  in  1  convolutional_layer valid
  layer_output_data  in  CHANNELS_OUT*O_WIDTH  convolutional_layer output_data
  out_data  out  CHANNELS_OUT*O_WIDTH  result pixel to downstream
  out_valid  out  1  result pixel present
  out_ready  in  1  downstream accepts
  busy  out  1  pass in progress
  done  out  1  one-cycle pulse, pass complete
  error  out  1  sticky, flush exceeded FLUSH_MAX; cleared by start

Function
REQ-008 SHALL implement states IDLE, PRIME, STREAM, FLUSH, FINISH.
REQ-009 IDLE: start=1 -> PRIME, clear read address, output count and flush count; start ignored in all other states.
REQ-010 PRIME (one cycle): src_rd_en=1, src_addr=0, layer_clk_en=0; -> STREAM.
REQ-011 STREAM/FLUSH: layer_clk_en SHALL equal out_ready; no layer advance while downstream stalls.
REQ-012 STREAM: each cycle with layer_clk_en=1, layer consumes src_data; if reads remain, src_rd_en=1 and src_addr increments by 1.
REQ-013 After the layer consumes pixel N_IN-1 -> FLUSH; src_rd_en stays 0.
REQ-014 FLUSH: layer_input_data SHALL be all zeros; flush counter increments per layer_clk_en cycle.
REQ-015 layer_input_data SHALL equal src_data in STREAM, zero otherwise.
REQ-016 out_valid SHALL equal layer_valid AND state in {STREAM, FLUSH}; out_data = layer_output_data combinationally.
REQ-017 Transfer = out_valid AND out_ready; output count increments by 1 per transfer.
REQ-018 Transfer completing output count N_OUT -> FINISH, from STREAM or FLUSH.
REQ-019 FINISH (one cycle): done=1, layer_clk_en=0; -> IDLE.
REQ-020 FLUSH counter reaching FLUSH_MAX before N_OUT transfers: error=1, -> IDLE, no done pulse.
REQ-021 abort=1 in any non-IDLE state -> IDLE next cycle; no done; counters cleared; abort beats simultaneous transfer.
REQ-022 busy=1 in PRIME, STREAM, FLUSH, FINISH.
REQ-023 Address counter SHALL never exceed N_IN-1; no wrap-around.

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE, all counters 0, src_addr=0, and all outputs 0, including error and layer_input_data.
REQ-025 Reset mid-pass SHALL discard the pass; first action after release is waiting for start.

Verification
REQ-026 Default parameters, out_ready=1, start pulse -> src_addr 0..2047 once each, exactly 1680 out_valid transfers, done one cycle after last, busy low after.
REQ-027 out_ready toggled 1/0 every cycle -> layer_clk_en mirrors out_ready; same 1680 outputs in identical order to unstalled run.
REQ-028 start asserted while busy -> ignored; counts and done timing unchanged.
REQ-029 Layer model never asserts valid -> error=1 after 256 flush cycles; no done; next start clears error.
REQ-030 abort at transfer 500 -> IDLE next cycle, busy=0, no done; a new start restarts at src_addr 0.
REQ-031 rst_n low mid-STREAM, asynchronously between edges -> all outputs 0 immediately, IDLE retained until start.
